// File: rtl/sap_bus_pkg.sv
// Shared types and sizing helpers for the SAP bus arbiter.
package sap_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVEN  = 2'd1,
      CONTEND = 2'd2
   } bus_state_e;

   localparam int unsigned DefDataW    = 8;
   localparam int unsigned DefNSrc     = 6;
   localparam int unsigned DefKeepLast = 1;
   localparam int unsigned DefErrCntW  = 8;

   // A single source still needs a 1-bit index so the port never collapses.
   function automatic int unsigned src_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sap_bus_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; also flags any/multiple requests.
module sap_bus_prio_enc #(
   parameter int unsigned N_SRC = 6,
   parameter int unsigned IDX_W = 3
) (
   input  logic [N_SRC-1:0] req_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             any_req_o,
   output logic             multi_req_o
);

   logic seen;

   always_comb begin
      winner_o = '0;
      // Scan downwards so the lowest index is the last, winning assignment.
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (req_i[i]) winner_o = IDX_W'(i);
      end
   end

   always_comb begin
      seen        = 1'b0;
      multi_req_o = 1'b0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (req_i[i]) begin
            if (seen) multi_req_o = 1'b1;
            seen = 1'b1;
         end
      end
      any_req_o = seen;
   end

endmodule

// File: rtl/sap_bus_arbiter.sv
// Registered bus arbiter: selects one source per cycle, tracks multi-driver contention.
module sap_bus_arbiter
   import sap_bus_pkg::*;
#(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned N_SRC     = DefNSrc,
   parameter int unsigned KEEP_LAST = DefKeepLast,
   parameter int unsigned ERR_CNT_W = DefErrCntW
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_SRC*DATA_W-1:0]        src_data,
   input  logic [N_SRC-1:0]               src_oe,
   input  logic                           hold,
   input  logic                           clr_err,
   output logic [DATA_W-1:0]              databus,
   output logic                           bus_valid,
   output logic [src_idx_w(N_SRC)-1:0]    bus_src,
   output logic [1:0]                     bus_state,
   output logic                           contention,
   output logic                           contention_sticky,
   output logic [ERR_CNT_W-1:0]           contention_cnt
);

   localparam int unsigned IDX_W = src_idx_w(N_SRC);
   localparam logic [ERR_CNT_W-1:0] CntMax = '1;

   logic [IDX_W-1:0]     winner;
   logic                 any_req;
   logic                 multi_req;
   logic [DATA_W-1:0]    win_data;

   logic [DATA_W-1:0]    data_q;
   logic                 valid_q;
   logic [IDX_W-1:0]     src_q;
   bus_state_e           state_q;
   logic                 cont_q;
   logic                 sticky_q;
   logic [ERR_CNT_W-1:0] cnt_q;

   sap_bus_prio_enc #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_prio_enc (
      .req_i       (src_oe),
      .winner_o    (winner),
      .any_req_o   (any_req),
      .multi_req_o (multi_req)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (winner == IDX_W'(i)) win_data = src_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         src_q    <= '0;
         state_q  <= IDLE;
         cont_q   <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         // Clear applies even while held; a same-cycle contention below then counts from zero.
         if (clr_err) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
         end
         if (!hold) begin
            if (any_req) begin
               data_q  <= win_data;
               src_q   <= winner;
               valid_q <= 1'b1;
            end else begin
               valid_q <= 1'b0;
               if (KEEP_LAST == 0) data_q <= '0;
            end
            cont_q <= multi_req;
            if (multi_req) begin
               state_q  <= CONTEND;
               sticky_q <= 1'b1;
               if (clr_err)              cnt_q <= ERR_CNT_W'(1);
               else if (cnt_q != CntMax) cnt_q <= cnt_q + ERR_CNT_W'(1);
            end else if (any_req) begin
               state_q <= DRIVEN;
            end else begin
               state_q <= IDLE;
            end
         end
      end
   end

   assign databus           = data_q;
   assign bus_valid         = valid_q;
   assign bus_src           = src_q;
   assign bus_state         = state_q;
   assign contention        = cont_q;
   assign contention_sticky = sticky_q;
   assign contention_cnt    = cnt_q;

endmodule

// File: tb/tb_sap_bus_arbiter.sv
// Vector-table bench for sap_bus_arbiter: default, KEEP_LAST=0 and ERR_CNT_W=2 instances share inputs.
module tb_sap_bus_arbiter;
   import sap_bus_pkg::*;

   localparam logic [47:0] DA = 48'hC3FF_5AA5_3C11;  // src0..5 = 11 3C A5 5A FF C3
   localparam logic [47:0] DB = 48'h0102_0304_0506;  // src0..5 = 06 05 04 03 02 01

   typedef struct packed {
      logic        rst;
      logic        hold;
      logic        clr;
      logic [5:0]  oe;
      logic [47:0] data;
      logic [7:0]  e_data;
      logic        e_valid;
      logic [2:0]  e_src;
      logic [1:0]  e_state;
      logic        e_cont;
      logic        e_sticky;
      logic [7:0]  e_cnt;
      logic [7:0]  e_k0;
      logic [1:0]  e_c2;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [47:0] src_data = '0;
   logic [5:0]  src_oe = '0;
   logic        hold = 1'b0;
   logic        clr_err = 1'b0;

   logic [7:0] a_data, k_data, c_data;
   logic       a_valid, k_valid, c_valid;
   logic [2:0] a_src, k_src, c_src;
   logic [1:0] a_state, k_state, c_state;
   logic       a_cont, k_cont, c_cont;
   logic       a_sticky, k_sticky, c_sticky;
   logic [7:0] a_cnt, k_cnt;
   logic [1:0] c_cnt;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   sap_bus_arbiter dut (
      .clk (clk), .rst (rst), .src_data (src_data), .src_oe (src_oe), .hold (hold),
      .clr_err (clr_err), .databus (a_data), .bus_valid (a_valid), .bus_src (a_src),
      .bus_state (a_state), .contention (a_cont), .contention_sticky (a_sticky),
      .contention_cnt (a_cnt)
   );

   sap_bus_arbiter #(.KEEP_LAST (0)) dut_k0 (
      .clk (clk), .rst (rst), .src_data (src_data), .src_oe (src_oe), .hold (hold),
      .clr_err (clr_err), .databus (k_data), .bus_valid (k_valid), .bus_src (k_src),
      .bus_state (k_state), .contention (k_cont), .contention_sticky (k_sticky),
      .contention_cnt (k_cnt)
   );

   sap_bus_arbiter #(.ERR_CNT_W (2)) dut_c2 (
      .clk (clk), .rst (rst), .src_data (src_data), .src_oe (src_oe), .hold (hold),
      .clr_err (clr_err), .databus (c_data), .bus_valid (c_valid), .bus_src (c_src),
      .bus_state (c_state), .contention (c_cont), .contention_sticky (c_sticky),
      .contention_cnt (c_cnt)
   );

   function automatic vec_t mk(input logic r, input logic h, input logic c, input logic [5:0] oe,
                               input logic [47:0] d, input logic [7:0] ed, input logic ev,
                               input logic [2:0] es, input logic [1:0] est, input logic ec,
                               input logic esk, input logic [7:0] ecnt, input logic [7:0] ek0,
                               input logic [1:0] ec2);
      vec_t v;
      v.rst = r; v.hold = h; v.clr = c; v.oe = oe; v.data = d;
      v.e_data = ed; v.e_valid = ev; v.e_src = es; v.e_state = est; v.e_cont = ec;
      v.e_sticky = esk; v.e_cnt = ecnt; v.e_k0 = ek0; v.e_c2 = ec2;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Drive at the falling edge, queue the expectation, compare 1 ns after the rising edge.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      rst = v.rst; hold = v.hold; clr_err = v.clr; src_oe = v.oe; src_data = v.data;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("databus",   idx, a_data, e.e_data);
      chk("bus_valid", idx, 8'(a_valid), 8'(e.e_valid));
      chk("bus_src",   idx, 8'(a_src), 8'(e.e_src));
      chk("bus_state", idx, 8'(a_state), 8'(e.e_state));
      chk("contention", idx, 8'(a_cont), 8'(e.e_cont));
      chk("sticky",    idx, 8'(a_sticky), 8'(e.e_sticky));
      chk("cnt",       idx, a_cnt, e.e_cnt);
      chk("k0.databus", idx, k_data, e.e_k0);
      chk("k0.bus_valid", idx, 8'(k_valid), 8'(e.e_valid));
      chk("k0.bus_src", idx, 8'(k_src), 8'(e.e_src));
      chk("k0.bus_state", idx, 8'(k_state), 8'(e.e_state));
      chk("k0.contention", idx, 8'(k_cont), 8'(e.e_cont));
      chk("k0.sticky", idx, 8'(k_sticky), 8'(e.e_sticky));
      chk("k0.cnt",    idx, k_cnt, e.e_cnt);
      chk("c2.databus", idx, c_data, e.e_data);
      chk("c2.bus_valid", idx, 8'(c_valid), 8'(e.e_valid));
      chk("c2.bus_src", idx, 8'(c_src), 8'(e.e_src));
      chk("c2.bus_state", idx, 8'(c_state), 8'(e.e_state));
      chk("c2.contention", idx, 8'(c_cont), 8'(e.e_cont));
      chk("c2.sticky", idx, 8'(c_sticky), 8'(e.e_sticky));
      chk("c2.cnt",    idx, 8'(c_cnt), 8'(e.e_c2));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      //              rst  hold clr  oe         data data bv src state    cont stk cnt    k0     c2
      vecs.push_back(mk(1, 0, 0, 6'b000100, DA, 8'h00, 0, 0, IDLE,    0, 0, 8'd0, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b000100, DA, 8'hA5, 1, 2, DRIVEN,  0, 0, 8'd0, 8'hA5, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b010010, DA, 8'h3C, 1, 1, CONTEND, 1, 1, 8'd1, 8'h3C, 2'd1));
      vecs.push_back(mk(0, 0, 0, 6'b001000, DA, 8'h5A, 1, 3, DRIVEN,  0, 1, 8'd1, 8'h5A, 2'd1));
      vecs.push_back(mk(0, 0, 0, 6'b000000, DA, 8'h5A, 0, 3, IDLE,    0, 1, 8'd1, 8'h00, 2'd1));
      vecs.push_back(mk(0, 0, 0, 6'b000000, DA, 8'h5A, 0, 3, IDLE,    0, 1, 8'd1, 8'h00, 2'd1));
      vecs.push_back(mk(0, 0, 1, 6'b000000, DA, 8'h5A, 0, 3, IDLE,    0, 0, 8'd0, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b111111, DA, 8'h11, 1, 0, CONTEND, 1, 1, 8'd1, 8'h11, 2'd1));
      vecs.push_back(mk(0, 0, 0, 6'b100001, DA, 8'h11, 1, 0, CONTEND, 1, 1, 8'd2, 8'h11, 2'd2));
      vecs.push_back(mk(0, 0, 0, 6'b110000, DA, 8'hFF, 1, 4, CONTEND, 1, 1, 8'd3, 8'hFF, 2'd3));
      vecs.push_back(mk(0, 0, 0, 6'b001100, DA, 8'hA5, 1, 2, CONTEND, 1, 1, 8'd4, 8'hA5, 2'd3));
      vecs.push_back(mk(0, 0, 0, 6'b101000, DA, 8'h5A, 1, 3, CONTEND, 1, 1, 8'd5, 8'h5A, 2'd3));
      vecs.push_back(mk(0, 0, 1, 6'b000011, DA, 8'h11, 1, 0, CONTEND, 1, 1, 8'd1, 8'h11, 2'd1));
      vecs.push_back(mk(0, 0, 0, 6'b100000, DA, 8'hC3, 1, 5, DRIVEN,  0, 1, 8'd1, 8'hC3, 2'd1));
      vecs.push_back(mk(0, 1, 0, 6'b000011, DB, 8'hC3, 1, 5, DRIVEN,  0, 1, 8'd1, 8'hC3, 2'd1));
      vecs.push_back(mk(0, 1, 0, 6'b000000, DA, 8'hC3, 1, 5, DRIVEN,  0, 1, 8'd1, 8'hC3, 2'd1));
      vecs.push_back(mk(0, 1, 0, 6'b000100, DB, 8'hC3, 1, 5, DRIVEN,  0, 1, 8'd1, 8'hC3, 2'd1));
      vecs.push_back(mk(0, 0, 0, 6'b000100, DB, 8'h04, 1, 2, DRIVEN,  0, 1, 8'd1, 8'h04, 2'd1));
      vecs.push_back(mk(0, 1, 1, 6'b110000, DA, 8'h04, 1, 2, DRIVEN,  0, 0, 8'd0, 8'h04, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b011000, DA, 8'h5A, 1, 3, CONTEND, 1, 1, 8'd1, 8'h5A, 2'd1));
      vecs.push_back(mk(0, 0, 1, 6'b000100, DA, 8'hA5, 1, 2, DRIVEN,  0, 0, 8'd0, 8'hA5, 2'd0));
      vecs.push_back(mk(1, 0, 0, 6'b000100, DA, 8'h00, 0, 0, IDLE,    0, 0, 8'd0, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b000100, DA, 8'hA5, 1, 2, DRIVEN,  0, 0, 8'd0, 8'hA5, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b010010, DA, 8'h3C, 1, 1, CONTEND, 1, 1, 8'd1, 8'h3C, 2'd1));
      vecs.push_back(mk(1, 1, 0, 6'b010010, DA, 8'h00, 0, 0, IDLE,    0, 0, 8'd0, 8'h00, 2'd0));
      vecs.push_back(mk(0, 0, 0, 6'b000000, DA, 8'h00, 0, 0, IDLE,    0, 0, 8'd0, 8'h00, 2'd0));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Long contention run: 8-bit counter saturates at 255, 2-bit copy at 3.
      for (int n = 1; n <= 260; n++) begin
         apply(mk(0, 0, 0, 6'b000011, DA, 8'h11, 1, 0, CONTEND, 1, 1,
                  8'((n > 255) ? 255 : n), 8'h11, 2'((n > 3) ? 3 : n)), 100 + n);
      end
      apply(mk(0, 0, 1, 6'b000000, DA, 8'h11, 0, 0, IDLE, 0, 0, 8'd0, 8'h00, 2'd0), 400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
